// File: rtl/inst_mem_loader.sv
// Boot-time instruction loader: packs 16-bit halfwords pairwise into 32-bit
// instruction-memory writes and holds fetch stalled until the load completes.
module inst_mem_loader #(
   parameter int          ADDR_W   = 32,
   parameter int          CNT_W    = 21,
   parameter logic [15:0] PAD_HALF = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Load_Start,
   input  logic [ADDR_W-1:0] Load_Base,
   input  logic [CNT_W-1:0]  Load_Count,
   input  logic [15:0]       Data_In,
   input  logic              Data_Valid,
   output logic              Data_Ready,
   output logic [ADDR_W-1:0] Write_Address,
   output logic [31:0]       OP_Code,
   output logic              Write_Enable,
   output logic              Fetch_Stall,
   output logic              Load_Busy,
   output logic              Load_Done,
   output logic [CNT_W-1:0]  Halfword_Count
);

   typedef enum logic [2:0] {IDLE, CAP_HI, CAP_LO, WRITE, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [CNT_W-1:0]  hcnt_q, hcnt_d;
   logic [15:0]       hi_q, hi_d;
   logic [15:0]       lo_q, lo_d;
   logic [31:0]       op_q, op_d;
   logic              ready_q, ready_d;
   logic              we_q, we_d;
   logic              stall_q, stall_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              hs;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      waddr_d = waddr_q;
      rem_d   = rem_q;
      hcnt_d  = hcnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      op_d    = op_q;
      hs      = Data_Valid && ready_q;

      case (state_q)
         IDLE, DONE: begin
            if (Load_Start) begin
               if (Load_Count != '0) begin
                  addr_d  = Load_Base;
                  rem_d   = Load_Count;
                  hcnt_d  = '0;
                  state_d = CAP_HI;
               end else begin
                  state_d = DONE;
               end
            end
         end
         CAP_HI: begin
            if (hs) begin
               hi_d   = Data_In;
               rem_d  = rem_q - CNT_W'(1);
               hcnt_d = hcnt_q + CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  // Odd count: the final halfword is paired with padding.
                  lo_d    = PAD_HALF;
                  op_d    = {Data_In, PAD_HALF};
                  waddr_d = addr_q;
                  state_d = WRITE;
               end else begin
                  state_d = CAP_LO;
               end
            end
         end
         CAP_LO: begin
            if (hs) begin
               lo_d    = Data_In;
               rem_d   = rem_q - CNT_W'(1);
               hcnt_d  = hcnt_q + CNT_W'(1);
               op_d    = {hi_q, Data_In};
               waddr_d = addr_q;
               state_d = WRITE;
            end
         end
         WRITE: begin
            addr_d  = addr_q + ADDR_W'(2);
            state_d = (rem_q == '0) ? DONE : CAP_HI;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they leave a flop.
      ready_d = (state_d == CAP_HI) || (state_d == CAP_LO);
      we_d    = (state_d == WRITE);
      busy_d  = (state_d == CAP_HI) || (state_d == CAP_LO) || (state_d == WRITE);
      done_d  = (state_d == DONE);
      stall_d = (state_d != DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         waddr_q <= '0;
         rem_q   <= '0;
         hcnt_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         op_q    <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         stall_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         waddr_q <= waddr_d;
         rem_q   <= rem_d;
         hcnt_q  <= hcnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         op_q    <= op_d;
         ready_q <= ready_d;
         we_q    <= we_d;
         stall_q <= stall_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Data_Ready     = ready_q;
   assign Write_Address  = waddr_q;
   assign OP_Code        = op_q;
   assign Write_Enable   = we_q;
   assign Fetch_Stall    = stall_q;
   assign Load_Busy      = busy_q;
   assign Load_Done      = done_q;
   assign Halfword_Count = hcnt_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: halfword streams, write capture and
// immediate-assertion checks against hand-computed addresses and opcodes.
module tb_inst_mem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        Load_Start;
   logic [31:0] Load_Base;
   logic [20:0] Load_Count;
   logic [15:0] Data_In;
   logic        Data_Valid;
   logic        Data_Ready;
   logic [31:0] Write_Address;
   logic [31:0] OP_Code;
   logic        Write_Enable;
   logic        Fetch_Stall;
   logic        Load_Busy;
   logic        Load_Done;
   logic [20:0] Halfword_Count;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int we_double = 0;
   logic we_prev = 1'b0;
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          wc[$];

   inst_mem_loader dut (
      .clk(clk), .rst(rst), .Load_Start(Load_Start), .Load_Base(Load_Base),
      .Load_Count(Load_Count), .Data_In(Data_In), .Data_Valid(Data_Valid),
      .Data_Ready(Data_Ready), .Write_Address(Write_Address), .OP_Code(OP_Code),
      .Write_Enable(Write_Enable), .Fetch_Stall(Fetch_Stall), .Load_Busy(Load_Busy),
      .Load_Done(Load_Done), .Halfword_Count(Halfword_Count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (Write_Enable) begin
         wa.push_back(Write_Address);
         wd.push_back(OP_Code);
         wc.push_back(cyc);
         if (we_prev) we_double++;
      end
      we_prev = Write_Enable;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
      wc.delete();
      we_double = 0;
   endtask

   task automatic start(input logic [31:0] base, input logic [20:0] count);
      Load_Start = 1'b1;
      Load_Base  = base;
      Load_Count = count;
      tick();
      Load_Start = 1'b0;
   endtask

   task automatic send(input logic [15:0] d, input int gap);
      int  n;
      bit  hs;
      n  = 0;
      Data_In    = d;
      Data_Valid = 1'b1;
      do begin
         hs = Data_Ready;
         tick();
         n++;
      end while (!hs && n < 40);
      chk("handshake", 64'(hs), 64'd1);
      if (gap > 0) begin
         Data_Valid = 1'b0;
         for (int i = 0; i < gap; i++) begin
            chk("ready_in_gap", 64'(Data_Ready), 64'd1);
            tick();
         end
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      Data_Valid = 1'b0;
      while (!Load_Done && n < 100) begin
         tick();
         n++;
      end
      chk("done_reached", 64'(Load_Done), 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; Load_Start = 1'b0; Load_Base = '0; Load_Count = '0;
      Data_In = '0; Data_Valid = 1'b0;

      // Reset and idle
      do_reset();
      chk("rst_stall", 64'(Fetch_Stall), 64'd1);
      chk("rst_we",    64'(Write_Enable), 64'd0);
      chk("rst_ready", 64'(Data_Ready), 64'd0);
      chk("rst_done",  64'(Load_Done), 64'd0);
      chk("rst_busy",  64'(Load_Busy), 64'd0);
      chk("rst_hcnt",  64'(Halfword_Count), 64'd0);
      chk("rst_op",    64'(OP_Code), 64'd0);
      chk("rst_addr",  64'(Write_Address), 64'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("idle_stall", 64'(Fetch_Stall), 64'd1);
      chk("idle_ready", 64'(Data_Ready), 64'd0);
      chk("idle_done",  64'(Load_Done), 64'd0);
      chk("idle_writes", 64'(wa.size()), 64'd0);

      // Four halfwords at 0x100, valid held high
      clear_log();
      start(32'h100, 21'd4);
      chk("l4_busy",  64'(Load_Busy), 64'd1);
      chk("l4_ready", 64'(Data_Ready), 64'd1);
      chk("l4_stall", 64'(Fetch_Stall), 64'd1);
      send(16'h1111, 0);
      send(16'h2222, 0);
      send(16'h3333, 0);
      send(16'h4444, 0);
      wait_done();
      chk("l4_nwr",   64'(wa.size()), 64'd2);
      chk("l4_a0",    64'(wa[0]), 64'h100);
      chk("l4_d0",    64'(wd[0]), 64'h11112222);
      chk("l4_a1",    64'(wa[1]), 64'h102);
      chk("l4_d1",    64'(wd[1]), 64'h33334444);
      chk("l4_rate",  64'(wc[1] - wc[0]), 64'd3);
      chk("l4_stall_done", 64'(Fetch_Stall), 64'd0);
      chk("l4_busy_done",  64'(Load_Busy), 64'd0);
      chk("l4_hcnt",  64'(Halfword_Count), 64'd4);
      chk("l4_hold_addr", 64'(Write_Address), 64'h102);
      chk("l4_hold_op",   64'(OP_Code), 64'h33334444);

      // Odd count from DONE: padding in the low half
      clear_log();
      start(32'h10, 21'd3);
      chk("restart_done",  64'(Load_Done), 64'd0);
      chk("restart_stall", 64'(Fetch_Stall), 64'd1);
      send(16'hAAAA, 0);
      send(16'hBBBB, 0);
      send(16'hCCCC, 0);
      wait_done();
      chk("l3_nwr", 64'(wa.size()), 64'd2);
      chk("l3_a0",  64'(wa[0]), 64'h10);
      chk("l3_d0",  64'(wd[0]), 64'hAAAABBBB);
      chk("l3_a1",  64'(wa[1]), 64'h12);
      chk("l3_d1",  64'(wd[1]), 64'hCCCC0000);
      chk("l3_hcnt", 64'(Halfword_Count), 64'd3);

      // Valid gaps between halfwords
      clear_log();
      start(32'h200, 21'd2);
      send(16'h5555, 2);
      send(16'h6666, 0);
      wait_done();
      chk("gap_nwr", 64'(wa.size()), 64'd1);
      chk("gap_a0",  64'(wa[0]), 64'h200);
      chk("gap_d0",  64'(wd[0]), 64'h55556666);
      chk("gap_we_width", 64'(we_double), 64'd0);

      // Reset while in CAP_LO of a 6-halfword load
      clear_log();
      start(32'h300, 21'd6);
      send(16'h7001, 0);
      send(16'h7002, 0);
      send(16'h7003, 0);
      Data_Valid = 1'b0;
      rst = 1'b0;
      tick();
      chk("mid_rst_stall", 64'(Fetch_Stall), 64'd1);
      chk("mid_rst_we",    64'(Write_Enable), 64'd0);
      chk("mid_rst_busy",  64'(Load_Busy), 64'd0);
      chk("mid_rst_ready", 64'(Data_Ready), 64'd0);
      rst = 1'b1;
      Data_In = 16'h7004;
      Data_Valid = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      Data_Valid = 1'b0;
      chk("mid_rst_nwr", 64'(wa.size()), 64'd1);
      chk("mid_rst_d0",  64'(wd[0]), 64'h70017002);
      clear_log();
      start(32'h0, 21'd2);
      send(16'h8001, 0);
      send(16'h8002, 0);
      wait_done();
      chk("post_rst_nwr", 64'(wa.size()), 64'd1);
      chk("post_rst_a0",  64'(wa[0]), 64'h0);
      chk("post_rst_d0",  64'(wd[0]), 64'h80018002);

      // Zero count from IDLE goes straight to DONE
      do_reset();
      clear_log();
      start(32'h400, 21'd0);
      chk("zero_done",  64'(Load_Done), 64'd1);
      chk("zero_stall", 64'(Fetch_Stall), 64'd0);
      chk("zero_busy",  64'(Load_Busy), 64'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("zero_nwr", 64'(wa.size()), 64'd0);

      // Load_Start during a busy load is ignored
      clear_log();
      start(32'h500, 21'd4);
      send(16'h00A1, 0);
      Load_Start = 1'b1;
      Load_Base  = 32'h900;
      Load_Count = 21'd0;
      send(16'h00A2, 0);
      Load_Start = 1'b0;
      send(16'h00A3, 0);
      send(16'h00A4, 0);
      wait_done();
      chk("busy_nwr",  64'(wa.size()), 64'd2);
      chk("busy_a0",   64'(wa[0]), 64'h500);
      chk("busy_d0",   64'(wd[0]), 64'h00A100A2);
      chk("busy_a1",   64'(wa[1]), 64'h502);
      chk("busy_d1",   64'(wd[1]), 64'h00A300A4);
      chk("busy_hcnt", 64'(Halfword_Count), 64'd4);

      // Address crossing the 20-bit boundary
      clear_log();
      start(32'hFFFFE, 21'd4);
      send(16'hF001, 0);
      send(16'hF002, 0);
      send(16'hF003, 0);
      send(16'hF004, 0);
      wait_done();
      chk("wrap_nwr", 64'(wa.size()), 64'd2);
      chk("wrap_a0",  64'(wa[0]), 64'hFFFFE);
      chk("wrap_a1",  64'(wa[1]), 64'h100000);
      chk("wrap_d1",  64'(wd[1]), 64'hF003F004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
